cnn_main: RTL and testbench
===========================

# cnn_main

Top-level streaming digit classifier. It accepts a 28×28 8-bit grayscale image as a raster pixel stream and runs it through four stages:
- a 3×3 convolution layer with ReLU and requantisation,
- global summation pooling,
- a 10-class fully connected layer,
- argmax.

It emits the ten class scores serially, then the winning class. Weights are held in internal memories that the testbench preloads through hierarchical `$readmemh`.

## Interface
- `IMG_W`, default 28: image width in pixels.
- `IMG_H`, default 28: image height in pixels.
- `CH`, default 4: number of convolution output channels.
- `SHIFT`, default 8: arithmetic right shift applied in conv requantisation.
- `clk` input, 1 bit: the single clock; all logic is on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, 1 bit: `in_data` carries a pixel this cycle.
- `in_data` input, 8 bits unsigned: pixel value.
- `final_score` output, signed 32 bits: current class score.
- `fc_out_valid` output, 1 bit: `final_score` is valid; one pulse per class.
- `class_out` output, 4 bits: predicted class, 0–9.
- `class_value` output, signed 32 bits: score of the predicted class.
- `class_valid` output, 1 bit: one-cycle pulse when the prediction is ready.

## Operation
- **Weight memories** (no load port):
  - conv `weight_data[0:CH*9-1]`, signed 8-bit; index = ch*9 + ky*3 + kx.
  - fc `weights[0:10*CH-1]`, signed 8-bit; index = k*CH + c.
  - fc `biases[0:9]`, signed 32-bit.
- **Frame accept:**
  - Pixels are accepted in raster order, one per `in_valid` cycle; gaps between pixels are arbitrary.
  - Row and column counters wrap at `IMG_W` / `IMG_H`.
  - After pixel `IMG_W*IMG_H`, the block goes busy. `in_valid` is ignored while busy.
  - The first `in_valid` after `class_valid` starts a new frame.
- **Conv layer:**
  - Two row line buffers plus a 3×3 window, valid padding, output 26×26.
  - For a pixel at row ≥ 2 and col ≥ 2, acc[ch] = Σ w·pix over the 3×3 window.
    - w is signed 8-bit, pix is zero-extended; the accumulator is signed 32-bit.
  - Post-processing per channel:
    - ReLU: negative becomes 0.
    - Then `>>> SHIFT`.
    - Then clip to 0..255.
- **Pooling:** gap[ch] = 32-bit sum of all 676 conv outputs; no division.
- **FC layer:**
  - For k = 0..9, score_k = bias_k + Σ_c weights[k*CH+c]·gap[c].
  - 32-bit two's-complement arithmetic that wraps on overflow.
  - One MAC per cycle.
- **Argmax:**
  - Keeps the running maximum over scores as they are emitted.
  - Strict greater-than comparison, so on a tie the lowest index wins.
- **State machine:**
  - IDLE → RECV on the first accepted pixel.
  - RECV → FC once the last conv output has been accumulated.
  - FC → DONE after score 9.
  - DONE: `class_valid` pulses, then the block returns to IDLE.
- **Reset (any state):**
  - Clears counters, line buffers, gap accumulators and all outputs.
  - Aborts any frame in progress.

## Timing
- All outputs reset to 0.
- Conv result for an accepted pixel is registered 1 cycle after `in_valid`. It is added into gap 1 cycle later.
- The FC phase starts 2 cycles after the last pixel is accepted.
- Each class takes CH MAC cycles:
  - The accumulator is seeded with the bias on the first cycle.
  - `final_score` and `fc_out_valid` are registered on the cycle after the last MAC.
  - Pulses therefore arrive CH cycles apart, in order k = 0..9.
- `final_score` holds its value between pulses.
- `class_valid` goes high the cycle after the 10th `fc_out_valid` and lasts exactly one cycle.
- `class_out` and `class_value` update in that same cycle and hold until the next prediction or reset.
- Total latency from the last pixel to `class_valid` is at most 10*CH + 4 cycles.

## Structure
- Shared package holds the following constants:
  - `IMG_W`, `IMG_H`;
  - `NUM_CLASSES` = 10;
  - conv output size 26;
  - weight and accumulator widths.
- Natural sub-modules:
  - `conv3x3_relu`: line buffers, window, `weight_data`, requantisation.
  - `fc_argmax`: `weights`, `biases`, serial MAC, argmax.
- The top level holds the frame FSM and the gap accumulators.

## Test plan
- **Bias-only scores:** zero image, all conv and fc weights 0, biases = k, with bias[9] = 100.
  - Expect 10 `fc_out_valid` pulses with scores 0..8, then 100.
  - Expect `class_out` = 9 and `class_value` = 100.
- **Single-weight path:** pixel = 1 everywhere, SHIFT = 0, ch0 kernel all 1 (other channels 0), fc w[3][0] = 1 (others 0), biases 0.
  - Expect gap0 = 6084, score3 = 6084, `class_out` = 3.
- **Tie:** all biases 5, all weights 0.
  - Expect `class_out` = 0 and `class_value` = 5.
- **ReLU and saturation:** SHIFT = 0, pixel 10 with ch0 kernel −1, and pixel 255 with ch1 kernel 127.
  - Expect gap0 = 0 and gap1 = 255·676 = 172380.
- **Reset mid-frame:** assert `rst` after 300 pixels, then send the full image from the single-weight-path test.
  - Expect an identical result (`class_out` = 3).
  - Expect no `fc_out_valid` pulse from the aborted frame.
- **Stream timing:** run back-to-back pixels and again with 50-cycle gaps, followed by 100 extra zero pixels.
  - Expect the same scores in both cases.
  - Extra pixels arriving while busy are ignored.

Source files
------------

// File: rtl/cnn_main_pkg.sv
// Shared constants and types for the streaming digit classifier.
package cnn_main_pkg;

  localparam int IMG_W       = 28;
  localparam int IMG_H       = 28;
  localparam int NUM_CLASSES = 10;
  localparam int CONV_OUT    = 26;
  localparam int PIX_WIDTH   = 8;
  localparam int W_WIDTH     = 8;
  localparam int ACC_WIDTH   = 32;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FC,
    DONE
  } state_t;

endpackage

// File: rtl/cnn_main_conv3x3_relu.sv
// 3x3 valid-padding convolution over a raster pixel stream, with ReLU,
// arithmetic requantisation shift and clipping to 0..255 per channel.
module conv3x3_relu #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CH    = 4,
  parameter int SHIFT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_valid,
  input  logic [7:0]          pix,
  output logic                last_pix,
  output logic                conv_valid,
  output logic                conv_last,
  output logic [CH-1:0][7:0]  conv_out
);
  import cnn_main_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic signed [W_WIDTH-1:0]   weight_data [0:CH*9-1];
  logic [PIX_WIDTH-1:0]        line0 [0:IMG_W-1];
  logic [PIX_WIDTH-1:0]        line1 [0:IMG_W-1];
  logic [PIX_WIDTH-1:0]        win   [0:2][0:1];
  logic [PIX_WIDTH-1:0]        taps  [0:2][0:2];
  logic [CW-1:0]               col;
  logic [RW-1:0]               row;
  logic [CH-1:0][7:0]          requant;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sh;

  assign last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

  // Window columns col-2 and col-1 come from registers, column col is live.
  always_comb begin
    acc     = '0;
    sh      = '0;
    requant = '0;
    for (int ky = 0; ky < 3; ky++) begin
      taps[ky][0] = win[ky][0];
      taps[ky][1] = win[ky][1];
    end
    taps[0][2] = line1[col];
    taps[1][2] = line0[col];
    taps[2][2] = pix;
    for (int ch = 0; ch < CH; ch++) begin
      acc = '0;
      for (int ky = 0; ky < 3; ky++) begin
        for (int kx = 0; kx < 3; kx++) begin
          acc = acc + ACC_WIDTH'(weight_data[ch*9 + ky*3 + kx]) *
                      $signed({24'd0, taps[ky][kx]});
        end
      end
      if (acc < 0) begin
        requant[ch] = 8'd0;
      end else begin
        sh = acc >>> SHIFT;
        requant[ch] = (sh > 32'sd255) ? 8'd255 : sh[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      conv_valid <= 1'b0;
      conv_last  <= 1'b0;
      conv_out   <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        line0[i] <= '0;
        line1[i] <= '0;
      end
      for (int ky = 0; ky < 3; ky++) begin
        win[ky][0] <= '0;
        win[ky][1] <= '0;
      end
    end else begin
      conv_valid <= pix_valid && (row >= RW'(2)) && (col >= CW'(2));
      conv_last  <= pix_valid && last_pix;
      if (pix_valid) begin
        conv_out   <= requant;
        line1[col] <= line0[col];
        line0[col] <= pix;
        for (int ky = 0; ky < 3; ky++) begin
          win[ky][0] <= win[ky][1];
          win[ky][1] <= taps[ky][2];
        end
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cnn_main_fc_argmax.sv
// Serial 10-class fully connected layer (one MAC per cycle) with a running
// strict-greater argmax over the emitted scores.
module fc_argmax #(
  parameter int CH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [CH-1:0][31:0] gap,
  output logic                fc_last,
  output logic signed [31:0]  final_score,
  output logic                fc_out_valid,
  output logic [3:0]          class_out,
  output logic signed [31:0]  class_value,
  output logic                class_valid
);
  import cnn_main_pkg::*;

  localparam int KW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int WIW = $clog2(NUM_CLASSES * CH);

  logic signed [W_WIDTH-1:0]   weights [0:NUM_CLASSES*CH-1];
  logic signed [ACC_WIDTH-1:0] biases  [0:NUM_CLASSES-1];

  logic [3:0]                  k;
  logic [KW-1:0]               c;
  logic [WIW-1:0]              widx;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] mac;
  logic [3:0]                  out_idx;
  logic signed [ACC_WIDTH-1:0] best_val;
  logic [3:0]                  best_idx;
  logic                        take_new;
  logic signed [ACC_WIDTH-1:0] nxt_val;
  logic [3:0]                  nxt_idx;

  assign widx    = WIW'(k * CH + c);
  assign base    = (c == '0) ? biases[k] : acc;
  assign mac     = base + ACC_WIDTH'(weights[widx]) * $signed(gap[c]);
  assign fc_last = run && (k == 4'(NUM_CLASSES - 1)) && (c == KW'(CH - 1));

  // The first score of a frame always seeds the running maximum.
  assign take_new = (out_idx == 4'd0) || (final_score > best_val);
  assign nxt_val  = take_new ? final_score : best_val;
  assign nxt_idx  = take_new ? out_idx : best_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      k            <= '0;
      c            <= '0;
      acc          <= '0;
      out_idx      <= '0;
      best_val     <= '0;
      best_idx     <= '0;
      final_score  <= '0;
      fc_out_valid <= 1'b0;
      class_out    <= '0;
      class_value  <= '0;
      class_valid  <= 1'b0;
    end else begin
      fc_out_valid <= 1'b0;
      class_valid  <= 1'b0;
      if (run) begin
        acc <= mac;
        if (c == KW'(CH - 1)) begin
          c            <= '0;
          k            <= k + 4'd1;
          final_score  <= mac;
          fc_out_valid <= 1'b1;
          out_idx      <= k;
        end else begin
          c <= c + KW'(1);
        end
      end else begin
        k <= '0;
        c <= '0;
      end
      if (fc_out_valid) begin
        best_val <= nxt_val;
        best_idx <= nxt_idx;
        if (out_idx == 4'(NUM_CLASSES - 1)) begin
          class_out   <= nxt_idx;
          class_value <= nxt_val;
          class_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cnn_main.sv
// Streaming digit classifier top: frame FSM, global-sum pooling, and the
// conv and fc/argmax stages.
module cnn_main #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CH    = 4,
  parameter int SHIFT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic signed [31:0] final_score,
  output logic               fc_out_valid,
  output logic [3:0]         class_out,
  output logic signed [31:0] class_value,
  output logic               class_valid
);
  import cnn_main_pkg::*;

  state_t                        state;
  logic                          full;
  logic                          accept;
  logic                          last_pix;
  logic                          conv_valid;
  logic                          conv_last;
  logic [CH-1:0][7:0]            conv_out;
  logic [CH-1:0][ACC_WIDTH-1:0]  gap;
  logic                          fc_last;

  // Once the last pixel of a frame is taken, input is ignored until the
  // prediction has been issued.
  assign accept = in_valid && ((state == IDLE) || ((state == RECV) && !full));

  conv3x3_relu #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CH    (CH),
    .SHIFT (SHIFT)
  ) u_conv (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (accept),
    .pix        (in_data),
    .last_pix   (last_pix),
    .conv_valid (conv_valid),
    .conv_last  (conv_last),
    .conv_out   (conv_out)
  );

  fc_argmax #(
    .CH (CH)
  ) u_fc (
    .clk          (clk),
    .rst          (rst),
    .run          (state == FC),
    .gap          (gap),
    .fc_last      (fc_last),
    .final_score  (final_score),
    .fc_out_valid (fc_out_valid),
    .class_out    (class_out),
    .class_value  (class_value),
    .class_valid  (class_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      full  <= 1'b0;
      gap   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RECV;
            gap   <= '0;
            full  <= last_pix;
          end
        end
        RECV: begin
          if (accept && last_pix) full <= 1'b1;
          if (conv_valid) begin
            for (int ch = 0; ch < CH; ch++) begin
              gap[ch] <= gap[ch] + ACC_WIDTH'(conv_out[ch]);
            end
            if (conv_last) begin
              state <= FC;
              full  <= 1'b0;
            end
          end
        end
        FC: begin
          if (fc_last) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_main.sv
// Scoreboard bench for cnn_main: a direct 2-D reference model queues the
// expected scores and prediction, and a monitor pops them as the DUT emits.
module tb_cnn_main;

  localparam int W        = 28;
  localparam int H        = 28;
  localparam int CH       = 4;
  localparam int SHIFT_TB = 0;
  localparam int NCLS     = 10;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [7:0]         in_data;
  logic signed [31:0] final_score;
  logic               fc_out_valid;
  logic [3:0]         class_out;
  logic signed [31:0] class_value;
  logic               class_valid;

  int checks;
  int errors;
  int class_seen;
  int cw  [CH*9];
  int fw  [NCLS*CH];
  int fb  [NCLS];
  int img [H][W];
  int score_q[$];
  int idx_q[$];
  int val_q[$];
  int last_score;
  int last_idx;
  int last_val;
  logic prev_cv;

  cnn_main #(
    .IMG_W (W),
    .IMG_H (H),
    .CH    (CH),
    .SHIFT (SHIFT_TB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .final_score  (final_score),
    .fc_out_valid (fc_out_valid),
    .class_out    (class_out),
    .class_value  (class_value),
    .class_valid  (class_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Monitor: every emitted score and prediction must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (fc_out_valid) begin
        if (score_q.size() == 0) checkOutput("spurious_fc_out_valid", 1, 0);
        else checkOutput("score", final_score, score_q.pop_front());
      end
      if (class_valid) begin
        if (prev_cv) checkOutput("class_valid_width", 2, 1);
        if (idx_q.size() == 0) begin
          checkOutput("spurious_class_valid", 1, 0);
        end else begin
          checkOutput("class_out", int'(class_out), idx_q.pop_front());
          checkOutput("class_value", class_value, val_q.pop_front());
        end
        class_seen++;
      end
      prev_cv = class_valid;
    end else begin
      prev_cv = 1'b0;
    end
  end

  task automatic clearModel();
    for (int i = 0; i < CH*9; i++) cw[i] = 0;
    for (int i = 0; i < NCLS*CH; i++) fw[i] = 0;
    for (int i = 0; i < NCLS; i++) fb[i] = 0;
  endtask

  task automatic setImage(input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic loadWeights();
    for (int i = 0; i < CH*9; i++) dut.u_conv.weight_data[i] = 8'(cw[i]);
    for (int i = 0; i < NCLS*CH; i++) dut.u_fc.weights[i] = 8'(fw[i]);
    for (int i = 0; i < NCLS; i++) dut.u_fc.biases[i] = 32'(fb[i]);
  endtask

  task automatic pushExpected();
    int gapm [CH];
    int acc;
    int sc;
    int best;
    int besti;
    best  = 0;
    besti = 0;
    for (int ch = 0; ch < CH; ch++) begin
      gapm[ch] = 0;
      for (int r = 2; r < H; r++) begin
        for (int c = 2; c < W; c++) begin
          acc = 0;
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              acc += cw[ch*9 + ky*3 + kx] * img[r-2+ky][c-2+kx];
          if (acc < 0) acc = 0;
          acc = acc >>> SHIFT_TB;
          if (acc > 255) acc = 255;
          gapm[ch] += acc;
        end
      end
    end
    for (int k = 0; k < NCLS; k++) begin
      sc = fb[k];
      for (int c = 0; c < CH; c++) sc += fw[k*CH + c] * gapm[c];
      score_q.push_back(sc);
      if (k == 0 || sc > best) begin
        best  = sc;
        besti = k;
      end
    end
    idx_q.push_back(besti);
    val_q.push_back(best);
    last_score = sc;
    last_idx   = besti;
    last_val   = best;
  endtask

  // Drives npix image pixels with gap_cycles idle cycles between them, then
  // extra zero pixels back to back.
  task automatic applyStimulus(input int gap_cycles, input int npix, input int extra);
    for (int p = 0; p < npix + extra; p++) begin
      if (p > 0 && p < npix) begin
        repeat (gap_cycles) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (p < npix) ? 8'(img[p / W][p % W]) : 8'd0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runFrame(input int gap_cycles, input int extra);
    int target;
    int n;
    target = class_seen + 1;
    loadWeights();
    pushExpected();
    applyStimulus(gap_cycles, W*H, extra);
    n = 0;
    while (class_seen < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("class_seen", class_seen, target);
    checkOutput("score_queue_empty", score_q.size(), 0);
    repeat (3) @(negedge clk);
    checkOutput("class_out_hold", int'(class_out), last_idx);
    checkOutput("class_value_hold", class_value, last_val);
    checkOutput("final_score_hold", final_score, last_score);
  endtask

  task automatic setSingleWeight();
    clearModel();
    setImage(1);
    for (int i = 0; i < 9; i++) cw[i] = 1;
    fw[3*CH + 0] = 1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    class_seen = 0;
    prev_cv    = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    clearModel();
    setImage(0);
    loadWeights();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_final_score", final_score, 0);
    checkOutput("reset_fc_out_valid", int'(fc_out_valid), 0);
    checkOutput("reset_class_out", int'(class_out), 0);
    checkOutput("reset_class_value", class_value, 0);
    checkOutput("reset_class_valid", int'(class_valid), 0);

    $display("[TB] bias-only scores");
    clearModel();
    setImage(0);
    for (int k = 0; k < NCLS; k++) fb[k] = k;
    fb[9] = 100;
    runFrame(0, 0);

    $display("[TB] single-weight path");
    setSingleWeight();
    runFrame(0, 0);

    $display("[TB] tie on equal biases");
    clearModel();
    setImage(37);
    for (int k = 0; k < NCLS; k++) fb[k] = 5;
    runFrame(0, 0);

    $display("[TB] relu and saturation");
    clearModel();
    for (int i = 0; i < 9; i++) cw[i] = -1;
    for (int i = 9; i < 18; i++) cw[i] = 127;
    fw[0*CH + 0] = 1;
    fw[1*CH + 1] = 1;
    setImage(10);
    runFrame(0, 0);
    setImage(255);
    runFrame(0, 0);

    $display("[TB] reset mid-frame");
    setSingleWeight();
    loadWeights();
    applyStimulus(0, 300, 0);
    resetDut();
    @(negedge clk);
    checkOutput("midreset_class_out", int'(class_out), 0);
    checkOutput("midreset_final_score", final_score, 0);
    runFrame(0, 0);

    $display("[TB] stream timing");
    resetDut();
    clearModel();
    for (int i = 0; i < CH*9; i++) cw[i] = ((i*37 + 11) % 15) - 7;
    for (int i = 0; i < NCLS*CH; i++) fw[i] = ((i*23 + 5) % 11) - 5;
    for (int k = 0; k < NCLS; k++) fb[k] = k*1000 - 3000;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = (r*7 + c*13 + r*c) % 256;
    runFrame(0, 0);
    runFrame(50, 100);
    repeat (150) @(negedge clk);
    checkOutput("after_extra_score_queue", score_q.size(), 0);
    resetDut();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
